// File: rtl/reel_engine_pkg.sv
// slot_pkg: shared FSM states, default pay constants and index sizing helper
package slot_pkg;
  typedef enum logic [1:0] {IDLE, SPIN, STOP, SCORE} state_t;
  localparam int DEF_N_REELS = 4;
  localparam int DEF_BET = 10;
  localparam int DEF_START_CREDIT = 100;
  localparam int DEF_PAIR_PAY = 15;
  localparam int DEF_JACKPOT_PAY = 500;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_IDX_W = idx_w(DEF_N_REELS);
endpackage

// File: rtl/reel_engine_if.sv
// reel_engine_if: timing/player inputs and display/score outputs of the reel engine
interface reel_engine_if #(
  parameter int N_REELS = 4,
  parameter int SYM_W = 4,
  parameter int CREDIT_W = 14
);
  logic tick;
  logic spin_req;
  logic [N_REELS*SYM_W-1:0] sym_in;
  logic [N_REELS*SYM_W-1:0] reel_sym;
  logic [N_REELS-1:0] stopped;
  logic spinning;
  logic [CREDIT_W-1:0] credit;
  logic is_broke;
  logic win_valid;
  logic [CREDIT_W-1:0] payout;
  modport master(
    output tick, spin_req, sym_in,
    input reel_sym, stopped, spinning, credit, is_broke, win_valid, payout
  );
  modport slave(
    input tick, spin_req, sym_in,
    output reel_sym, stopped, spinning, credit, is_broke, win_valid, payout
  );
endinterface

// File: rtl/reel_engine_scorer.sv
// match_scorer: payout for the displayed reels (pair pay, or jackpot when all match)
module match_scorer #(
  parameter int N_REELS = 4,
  parameter int SYM_W = 4,
  parameter int CREDIT_W = 14,
  parameter int PAIR_PAY = 15,
  parameter int JACKPOT_PAY = 500
) (
  input  logic [N_REELS*SYM_W-1:0] reel_sym,
  output logic [CREDIT_W-1:0]      payout
);
  logic [CREDIT_W-1:0] pair_sum;
  logic all_eq;
  // every matching neighbour adds pair pay; all neighbours matching means all reels equal
  always_comb begin
    pair_sum = '0;
    all_eq = 1'b1;
    for (int i = 0; i < N_REELS - 1; i++) begin
      if (reel_sym[i*SYM_W +: SYM_W] == reel_sym[(i+1)*SYM_W +: SYM_W]) pair_sum = pair_sum + CREDIT_W'(PAIR_PAY);
      else all_eq = 1'b0;
    end
    payout = all_eq ? CREDIT_W'(JACKPOT_PAY) : pair_sum;
  end
endmodule

// File: rtl/reel_engine.sv
// reel_engine: N-reel spin / timed-stop / early-stop / score / credit sequencer
module reel_engine
  import slot_pkg::*;
#(
  parameter int N_REELS = DEF_N_REELS,
  parameter int SYM_W = 4,
  parameter int CREDIT_W = 14,
  parameter int START_CREDIT = DEF_START_CREDIT,
  parameter int BET = DEF_BET,
  parameter int SPIN_TICKS = 4,
  parameter int STOP_TICKS = 2,
  parameter int PAIR_PAY = DEF_PAIR_PAY,
  parameter int JACKPOT_PAY = DEF_JACKPOT_PAY
) (
  input logic clk,
  input logic reset,
  reel_engine_if.slave bus
);
  localparam int KW = idx_w(N_REELS);
  localparam int CW = idx_w(SPIN_TICKS > STOP_TICKS ? SPIN_TICKS : STOP_TICKS);
  state_t state, state_n;
  logic spin_prev;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [CREDIT_W-1:0] score, credit_n;
  logic [CREDIT_W:0] sum;
  logic rise, start, spin_done, stop_ev;
  match_scorer #(
    .N_REELS(N_REELS), .SYM_W(SYM_W), .CREDIT_W(CREDIT_W),
    .PAIR_PAY(PAIR_PAY), .JACKPOT_PAY(JACKPOT_PAY)
  ) u_scorer (
    .reel_sym(bus.reel_sym),
    .payout(score)
  );
  // classify this cycle's events and choose next state and next credit
  always_comb begin
    rise = bus.spin_req & ~spin_prev;
    start = state == IDLE && rise && bus.credit >= CREDIT_W'(BET);
    spin_done = state == SPIN && bus.tick && cnt == CW'(SPIN_TICKS - 1);
    stop_ev = state == STOP && (rise || (bus.tick && cnt == CW'(STOP_TICKS - 1)));
    sum = {1'b0, bus.credit} + {1'b0, score};
    credit_n = start ? bus.credit - CREDIT_W'(BET)
             : state == SCORE ? (sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0])
             : bus.credit;
    state_n = start ? SPIN
            : spin_done ? STOP
            : (stop_ev && k == KW'(N_REELS - 1)) ? SCORE
            : state == SCORE ? IDLE
            : state;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // edge history, tick/reel counters, reel display and score outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      spin_prev <= 1'b0;
      cnt <= '0;
      k <= '0;
      bus.stopped <= '1;
      bus.reel_sym <= '0;
      bus.spinning <= 1'b0;
      bus.credit <= CREDIT_W'(START_CREDIT);
      bus.is_broke <= START_CREDIT < BET;
      bus.win_valid <= 1'b0;
      bus.payout <= '0;
    end else begin
      spin_prev <= bus.spin_req;
      for (int i = 0; i < N_REELS; i++)
        if (!bus.stopped[i]) bus.reel_sym[i*SYM_W +: SYM_W] <= bus.sym_in[i*SYM_W +: SYM_W];
      cnt <= (start || spin_done || stop_ev) ? '0
           : ((state == SPIN || state == STOP) && bus.tick) ? cnt + CW'(1)
           : cnt;
      k <= start ? '0 : stop_ev ? k + KW'(1) : k;
      if (start) bus.stopped <= '0;
      else if (stop_ev) bus.stopped[k] <= 1'b1;
      bus.spinning <= start ? 1'b1 : state == SCORE ? 1'b0 : bus.spinning;
      bus.credit <= credit_n;
      bus.is_broke <= credit_n < CREDIT_W'(BET);
      bus.win_valid <= state == SCORE;
      if (state == SCORE) bus.payout <= score;
    end
  end
endmodule

// File: tb/tb_reel_engine.sv
// tb_reel_engine: randomized spins against a rule-level payout/credit model with a scoreboard
module tb_reel_engine;
  localparam int N = 4;
  localparam int SW = 4;
  localparam int CW = 14;
  localparam int SYMW = N * SW;
  localparam int BET = 10;
  localparam int START = 100;
  localparam int ST = 4;
  localparam int TT = 2;
  localparam int PAIR = 15;
  localparam int JACK = 500;
  localparam int MAXC = 16383;

  typedef struct {
    int pay;
    int cred;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int credit_m = START;
  exp_t q[$];

  always #5 clk = ~clk;

  reel_engine_if #(.N_REELS(N), .SYM_W(SW), .CREDIT_W(CW)) bus();
  reel_engine_if #(.N_REELS(N), .SYM_W(SW), .CREDIT_W(CW)) bus2();

  assign bus2.tick = bus.tick;
  assign bus2.spin_req = bus.spin_req;
  assign bus2.sym_in = bus.sym_in;

  reel_engine #(
    .N_REELS(N), .SYM_W(SW), .CREDIT_W(CW), .START_CREDIT(START), .BET(BET),
    .SPIN_TICKS(ST), .STOP_TICKS(TT), .PAIR_PAY(PAIR), .JACKPOT_PAY(JACK)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  reel_engine #(
    .N_REELS(N), .SYM_W(SW), .CREDIT_W(CW), .START_CREDIT(16000), .BET(BET),
    .SPIN_TICKS(ST), .STOP_TICKS(TT), .PAIR_PAY(PAIR), .JACKPOT_PAY(JACK)
  ) dut_sat (.clk(clk), .reset(reset), .bus(bus2.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_pay(input int v[N]);
    int p = 0;
    bit all = 1'b1;
    for (int i = 0; i < N; i++) if (v[i] != v[0]) all = 1'b0;
    for (int i = 0; i < N - 1; i++) if (v[i] == v[i+1]) p++;
    return all ? JACK : p * PAIR;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    repeat ($urandom_range(0, 2)) step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    bus.tick = 1'b0;
    bus.spin_req = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_credit", bus.credit, START);
    chk("rst_broke", bus.is_broke, 0);
    chk("rst_stopped", bus.stopped, 4'hF);
    chk("rst_reel_sym", bus.reel_sym, 0);
    chk("rst_spinning", bus.spinning, 0);
    chk("rst_win", bus.win_valid, 0);
    chk("rst_payout", bus.payout, 0);
    reset = 1'b0;
    credit_m = START;
  endtask

  // mode per reel: 0 timed stop, 1 early spin_req edge, 2 edge coincident with tick expiry
  task automatic run_spin(input int v[N], input int mode[N], input int stop_cnt);
    int c;
    int mid;
    if (credit_m < BET) begin
      bus.spin_req = 1'b1;
      step();
      bus.spin_req = 1'b0;
      step();
      chk("broke_no_spin", bus.spinning, 0);
      chk("broke_credit", bus.credit, credit_m);
      chk("broke_flag", bus.is_broke, 1);
      chk("broke_stopped", bus.stopped, 4'hF);
      return;
    end
    mid = credit_m - BET;
    if (stop_cnt == N) begin
      c = mid + model_pay(v);
      credit_m = c > MAXC ? MAXC : c;
      q.push_back('{model_pay(v), credit_m});
    end
    bus.sym_in = SYMW'($urandom);
    bus.spin_req = 1'b1;
    step();
    bus.spin_req = 1'b0;
    chk("spin_start", bus.spinning, 1);
    chk("credit_debit", bus.credit, mid);
    chk("stopped_clear", bus.stopped, 0);
    for (int t = 0; t < ST; t++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.sym_in = SYMW'($urandom);
        bus.spin_req = 1'($urandom_range(0, 1));
        step();
      end
      bus.spin_req = 1'b0;
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
    end
    chk("spin_follow", bus.reel_sym, bus.sym_in);
    chk("spin_none_stopped", bus.stopped, 0);
    for (int k = 0; k < stop_cnt; k++) begin
      bus.sym_in = SYMW'($urandom);
      bus.sym_in[k*SW +: SW] = SW'(v[k]);
      if (mode[k] == 1) begin
        repeat ($urandom_range(0, TT - 1)) pulse_tick();
        repeat ($urandom_range(0, 2)) step();
        bus.spin_req = 1'b1;
        step();
      end else if (mode[k] == 2) begin
        repeat (TT - 1) pulse_tick();
        bus.tick = 1'b1;
        bus.spin_req = 1'b1;
        step();
      end else begin
        repeat (TT) pulse_tick();
      end
      bus.tick = 1'b0;
      bus.spin_req = 1'b0;
      chk($sformatf("stopped_order_%0d", k), bus.stopped, (1 << (k + 1)) - 1);
      chk($sformatf("reel_latch_%0d", k), bus.reel_sym[k*SW +: SW], v[k]);
      for (int j = k + 1; j < N; j++)
        chk($sformatf("reel_follow_%0d", j), bus.reel_sym[j*SW +: SW], bus.sym_in[j*SW +: SW]);
      if (k < N - 1) step();
    end
    if (stop_cnt == N) begin
      chk("spinning_in_score", bus.spinning, 1);
      step();
      chk("win_pulse", bus.win_valid, 1);
      chk("spinning_end", bus.spinning, 0);
      step();
      chk("win_single", bus.win_valid, 0);
    end
  endtask

  // scoreboard monitor: every win pulse must match the oldest expected result
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && bus.win_valid) begin
      if (q.size() == 0) chk("win_unexpected", bus.win_valid, 0);
      else begin
        e = q.pop_front();
        chk("payout", bus.payout, e.pay);
        chk("credit_after_score", bus.credit, e.cred);
        chk("broke_after_score", bus.is_broke, e.cred < BET);
      end
    end
  end

  initial begin
    int v[N];
    int m[N];
    int lim;
    bus.tick = 1'b0;
    bus.spin_req = 1'b0;
    bus.sym_in = '0;
    repeat (2) step();
    do_reset();
    v = '{3, 3, 3, 3};
    m = '{0, 0, 0, 0};
    run_spin(v, m, N);
    chk("sat_credit", bus2.credit, MAXC);
    do_reset();
    v = '{1, 2, 2, 5};
    run_spin(v, m, N);
    v = '{7, 7, 1, 1};
    m = '{1, 1, 2, 0};
    run_spin(v, m, N);
    m = '{2, 2, 1, 1};
    run_spin(v, m, N);
    do_reset();
    v = '{4, 4, 4, 9};
    m = '{0, 0, 0, 0};
    run_spin(v, m, 1);
    reset = 1'b1;
    step();
    chk("midstop_credit", bus.credit, START);
    chk("midstop_spinning", bus.spinning, 0);
    chk("midstop_stopped", bus.stopped, 4'hF);
    chk("midstop_reel_sym", bus.reel_sym, 0);
    reset = 1'b0;
    credit_m = START;
    v = '{1, 2, 3, 4};
    repeat (10) run_spin(v, m, N);
    chk("broke_credit_zero", bus.credit, 0);
    chk("broke_after_10", bus.is_broke, 1);
    run_spin(v, m, N);
    do_reset();
    repeat (30) begin
      lim = $urandom_range(1, 3);
      for (int i = 0; i < N; i++) begin
        v[i] = $urandom_range(0, lim);
        m[i] = $urandom_range(0, 2);
      end
      run_spin(v, m, N);
      if (credit_m < BET) begin
        run_spin(v, m, N);
        do_reset();
      end
    end
    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reel_engine.md
Name: reel_engine

Overview:
- Parametrised N-reel spin/stop/score/credit engine. It replaces the fixed four-reel stop sequencer and scoring pair in the slot-machine top level.
- Live reel symbols arrive from per-reel LFSRs.
- The engine sequences spin, timed stopping, player early-stop, payout and credit, and drives the display mux (reel_sym, stopped, spinning, credit).

Parameters:
N_REELS, 4, number of reels (2..8)
SYM_W, 4, bits per reel symbol
CREDIT_W, 14, credit register width (max 2^CREDIT_W-1 = 16383)
START_CREDIT, 100, credit loaded at reset
BET, 10, cost per spin
SPIN_TICKS, 4, ticks of free spin before stopping starts
STOP_TICKS, 2, ticks between automatic reel stops
PAIR_PAY, 15, payout per adjacent equal reel pair
JACKPOT_PAY, 500, payout when all reels are equal (replaces pair pay)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle timing strobe (2 Hz enable), sampled on clk
spin_req  in  1  debounced button level; only the rising edge acts
sym_in  in  N_REELS*SYM_W  live symbols; reel i at [i*SYM_W +: SYM_W]
reel_sym  out  N_REELS*SYM_W  displayed symbols
stopped  out  N_REELS  per-reel stopped flag
spinning  out  1  high from spin start until score
credit  out  CREDIT_W  current credit
is_broke  out  1  credit < BET
win_valid  out  1  one-cycle pulse at end of each spin
payout  out  CREDIT_W  payout of last spin; valid with win_valid, held until next score

Behaviour:
- All outputs are registered. spin_req edge detection uses one internal register, cleared by reset.
- Reset (any state, including mid-spin):
  - state=IDLE, credit=START_CREDIT, stopped=all 1, reel_sym=0.
  - spinning=0, win_valid=0, payout=0, tick/stop counters=0, reel index=0.
- is_broke = (credit < BET), registered alongside credit.
- IDLE:
  - On a spin_req rising edge with credit >= BET: at the next edge, credit -= BET, stopped=0, spinning=1, state=SPIN.
  - On an edge with credit < BET: ignored, no state change.
- SPIN:
  - reel_sym[i] follows sym_in[i] every cycle for every reel with stopped[i]=0.
  - Count ticks; on the SPIN_TICKS-th tick go to STOP and clear the counter.
  - spin_req edges are ignored in SPIN.
- STOP: the next reel (index k, ascending from 0) stops on either of two events:
  - the STOP_TICKS-th tick since entering STOP or since the last stop;
  - a spin_req rising edge (early stop).
- On a stop event: at the next edge, reel_sym[k] = sym_in[k], stopped[k]=1, k++, counter cleared.
  - A tick expiry and a spin_req edge in the same cycle stop exactly one reel.
- When the last reel is latched, go to SCORE.
- SCORE (single cycle): payout computed from reel_sym. At the next edge:
  - credit = min(credit + payout, 2^CREDIT_W-1) (saturating);
  - payout registered, win_valid=1 for that one cycle;
  - spinning=0, state=IDLE.
- Spin-to-idle latency with no early stops: SPIN_TICKS + N_REELS*STOP_TICKS ticks + 2 clk.
- Payout arithmetic:
  - all N_REELS symbols equal -> JACKPOT_PAY;
  - otherwise -> p*PAIR_PAY, where p = count of i in 0..N_REELS-2 with reel_sym[i]==reel_sym[i+1].
  - Computed at CREDIT_W width, no overflow before the add.
- A spin_req held high across a spin does not retrigger: a new edge is required in IDLE.

Decomposition:
- Package slot_pkg holds:
  - state enum {IDLE, SPIN, STOP, SCORE};
  - default constants for BET, START_CREDIT, PAIR_PAY, JACKPOT_PAY;
  - an index-width helper constant computed as clog2(N_REELS).
- One combinational sub-module, match_scorer (N_REELS, SYM_W, CREDIT_W, PAIR_PAY, JACKPOT_PAY): reel_sym in, payout out.

Test Plan:
- Reset -> credit=100, is_broke=0, stopped=4'b1111, reel_sym=0, spinning=0, win_valid=0.
- sym_in held 3,3,3,3; one spin_req edge; 12 ticks, no early stop -> spinning 1 then 0; credit 100->90->590; single win_valid pulse with payout=500.
- sym_in 1,2,2,5; spin -> payout=15, credit=105; stopped bits set in order 0,1,2,3, each 2 ticks apart after 4 spin ticks.
- sym_in 1,2,3,4 for 10 spins -> credit reaches 0, is_broke=1; an 11th spin_req edge -> spinning stays 0, credit stays 0.
- Early stop: 3 spin_req edges in STOP between ticks -> reels 0-2 latch one cycle after each edge. An edge coincident with a tick expiry stops only one reel.
- Reset asserted mid-STOP with credit=90 -> next cycle credit=100, spinning=0, stopped=1111. Separately, credit preloaded to 16000 with jackpot -> credit saturates at 16383.
